reset_request_gen: RTL and testbench
====================================

// Module: reset_request_gen
// PURPOSE
//  Initiator side of the fabric reset controller handshake. Collects reset causes:
//   - filtered PLL lock loss
//   - watchdog expiry
//   - software request
//  Drives the controller's EXT_RST_N request low and watches FABRIC_RESET_N for assert/release.
//  Retries on timeout. Reports cause, a completed-reset count and a sticky error.
//  Sits beside the reset controller; clocked from its free-running CLK.
// PARAMETERS
//  LOCK_FILT_LEN  16    consecutive samples needed to change filtered lock state
//  PULSE_LEN      8     minimum EXT_RST_N low time, cycles
//  ACK_TIMEOUT    1024  max cycles waiting for FABRIC_RESET_N assert or release
//  HOLDOFF_LEN    32    quiet cycles after completion; requests ignored
//  MAX_RETRY      3     timeouts tolerated before ERROR
// PORTS
//  CLK             in   1  system clock; single clock domain
//  RST             in   1  asynchronous, active-high reset
//  PLL_LOCK        in   1  async PLL lock; 2-FF synchronised inside
//  WDT_EXPIRE      in   1  sync 1-cycle pulse: watchdog request
//  SW_RST_REQ      in   1  sync 1-cycle pulse: software request
//  FABRIC_RESET_N  in   1  controller output; 2-FF synchronised inside
//  EXT_RST_N       out  1  reset request to controller, active-low
//  BUSY            out  1  high in any state other than IDLE
//  RST_CAUSE       out  3  {lock_loss, wdt, sw}; OR of requests in the accepting cycle
//  RST_COUNT       out  8  completed sequences, saturates at 255
//  TIMEOUT_ERR     out  1  sticky; set on entering ERROR
// BEHAVIOUR
//  Reset values (RST=1, async): EXT_RST_N=1, BUSY=0, RST_CAUSE=0, RST_COUNT=0,
//   TIMEOUT_ERR=0, state=IDLE, filtered lock=0, retry=0.
//  Lock filter:
//   - filtered lock flips only after LOCK_FILT_LEN equal synced samples.
//   - lock_loss event = filtered 1->0. Power-up lock=0 produces no event.
//  IDLE:
//   - any of lock_loss/WDT_EXPIRE/SW_RST_REQ in cycle n -> RST_CAUSE latched, retry=0.
//   - EXT_RST_N=0 and BUSY=1 from n+1, state ASSERT.
//  ASSERT:
//   - EXT_RST_N=0; count cycles.
//   - synced FABRIC_RESET_N==0 and count>=PULSE_LEN -> EXT_RST_N=1 next cycle, WAIT_HIGH.
//   - count==ACK_TIMEOUT -> timeout.
//  WAIT_HIGH:
//   - synced FABRIC_RESET_N==1 -> RST_COUNT+1 (sat), HOLDOFF.
//   - ACK_TIMEOUT cycles elapsed -> timeout.
//  Timeout:
//   - retry<MAX_RETRY -> retry+1, GAP (EXT_RST_N=1 for PULSE_LEN cycles), then ASSERT.
//   - else -> ERROR.
//  HOLDOFF: HOLDOFF_LEN cycles, then IDLE (BUSY=0).
//  ERROR: EXT_RST_N=1, BUSY=1, TIMEOUT_ERR=1; exits only via RST.
//  Requests outside IDLE are dropped. A lock loss is still captured by the filter;
//   filtered state is rechecked in IDLE and re-raises as a new event only on a
//   subsequent 1->0 edge.
//  Simultaneous causes: one sequence; all cause bits set.
//  Input sync latency: 2 cycles on PLL_LOCK and FABRIC_RESET_N, included in all timeouts.
//  RST mid-sequence: immediate return to reset values; EXT_RST_N released at once.
// STRUCTURE
//  Package reset_req_pkg: state enum {IDLE,ASSERT,WAIT_HIGH,GAP,HOLDOFF,ERROR};
//   cause bit indices CAUSE_SW=0, CAUSE_WDT=1, CAUSE_LOCK=2.
//  Sub-module reset_lock_filter: 2-FF sync + LOCK_FILT_LEN debounce counter;
//   outputs lock_filt and lock_loss pulse.
//  Top: FSM, shared cycle counter (ACK_TIMEOUT width), retry counter,
//   FABRIC_RESET_N synchroniser.
// TESTING
//  1. SW_RST_REQ pulse; model drops FABRIC_RESET_N after 3 cyc, releases 20 cyc after
//     EXT_RST_N rises.
//     -> EXT_RST_N low exactly 8 cyc, RST_CAUSE=3'b001, RST_COUNT=1,
//        BUSY=0 32 cyc after release.
//  2. After lock: PLL_LOCK low 10 cyc -> no request. PLL_LOCK low 20 cyc
//     -> request, RST_CAUSE=3'b100.
//  3. WDT_EXPIRE and SW_RST_REQ in same cycle -> one sequence, RST_CAUSE=3'b011,
//     RST_COUNT +1.
//  4. FABRIC_RESET_N stuck 1
//     -> 4 low windows of 1024 cyc separated by 8-cyc gaps, then TIMEOUT_ERR=1,
//        EXT_RST_N=1, BUSY=1 until RST.
//  5. RST pulse during WAIT_HIGH -> same cycle EXT_RST_N=1, BUSY=0, RST_CAUSE=0,
//     RST_COUNT=0.
//  6. SW_RST_REQ during HOLDOFF -> ignored. 256 completed sequences -> RST_COUNT holds 255.

Source files
------------

// File: rtl/reset_req_pkg.sv
// Shared types for the fabric reset request initiator: FSM states and cause bit layout.
package reset_req_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    WAIT_HIGH,
    GAP,
    HOLDOFF,
    ERROR
  } state_e;

  localparam int CAUSE_SW   = 0;
  localparam int CAUSE_WDT  = 1;
  localparam int CAUSE_LOCK = 2;
  localparam int CAUSE_W    = 3;

  typedef logic [CAUSE_W-1:0] cause_t;

endpackage

// File: rtl/reset_lock_filter.sv
// PLL lock synchroniser and debounce: the filtered state flips only after FILT_LEN
// consecutive equal synced samples; lock_loss pulses on a filtered 1->0 flip.
module reset_lock_filter
  import reset_req_pkg::*;
#(
  parameter int FILT_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  output logic lock_filt,
  output logic lock_loss
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic             loss_q, loss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    filt_d = filt_q;
    loss_d = 1'b0;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
        loss_d = filt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      loss_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      loss_q  <= loss_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lock_filt = filt_q;
  assign lock_loss = loss_q;

endmodule

// File: rtl/reset_request_gen.sv
// Initiator side of the fabric reset handshake: collects causes, drives EXT_RST_N low,
// tracks FABRIC_RESET_N assert/release with timeout, bounded retry and sticky error.
module reset_request_gen
  import reset_req_pkg::*;
#(
  parameter int LOCK_FILT_LEN = 16,
  parameter int PULSE_LEN     = 8,
  parameter int ACK_TIMEOUT   = 1024,
  parameter int HOLDOFF_LEN   = 32,
  parameter int MAX_RETRY     = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         PLL_LOCK,
  input  logic         WDT_EXPIRE,
  input  logic         SW_RST_REQ,
  input  logic         FABRIC_RESET_N,
  output logic         EXT_RST_N,
  output logic         BUSY,
  output logic [2:0]   RST_CAUSE,
  output logic [7:0]   RST_COUNT,
  output logic         TIMEOUT_ERR
);

  localparam int CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               ext_q, ext_d;
  logic               busy_q, busy_d;
  cause_t             cause_q, cause_d;
  logic [7:0]         count_q, count_d;
  logic               err_q, err_d;
  logic               fab_s1_q, fab_s2_q;
  logic               lock_filt, lock_loss;
  logic               timeout;
  cause_t             req;

  reset_lock_filter #(
    .FILT_LEN (LOCK_FILT_LEN)
  ) u_lock_filter (
    .clk       (CLK),
    .rst       (RST),
    .pll_lock  (PLL_LOCK),
    .lock_filt (lock_filt),
    .lock_loss (lock_loss)
  );

  always_comb begin
    req             = '0;
    req[CAUSE_SW]   = SW_RST_REQ;
    req[CAUSE_WDT]  = WDT_EXPIRE;
    req[CAUSE_LOCK] = lock_loss & ~lock_filt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
    ext_d   = ext_q;
    busy_d  = busy_q;
    cause_d = cause_q;
    count_d = count_q;
    err_d   = err_q;
    timeout = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (|req) begin
          state_d = ASSERT;
          ext_d   = 1'b0;
          busy_d  = 1'b1;
          cause_d = req;
          retry_d = '0;
          cnt_d   = CNT_W'(1);
        end
      end
      ASSERT: begin
        // cnt_q is the number of cycles EXT_RST_N has been low, including this one
        if (!fab_s2_q && cnt_q >= CNT_W'(PULSE_LEN)) begin
          state_d = WAIT_HIGH;
          ext_d   = 1'b1;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
          timeout = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (fab_s2_q) begin
          state_d = HOLDOFF;
          cnt_d   = CNT_W'(1);
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
          timeout = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(PULSE_LEN)) begin
          state_d = ASSERT;
          ext_d   = 1'b0;
          cnt_d   = CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_LEN)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      ERROR: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = IDLE;
        ext_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (timeout) begin
      ext_d = 1'b1;
      cnt_d = CNT_W'(1);
      if (retry_q < RETRY_W'(MAX_RETRY)) begin
        retry_d = retry_q + RETRY_W'(1);
        state_d = GAP;
      end else begin
        state_d = ERROR;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      retry_q  <= '0;
      ext_q    <= 1'b1;
      busy_q   <= 1'b0;
      cause_q  <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      fab_s1_q <= 1'b1;
      fab_s2_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      ext_q    <= ext_d;
      busy_q   <= busy_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
      err_q    <= err_d;
      fab_s1_q <= FABRIC_RESET_N;
      fab_s2_q <= fab_s1_q;
    end
  end

  assign EXT_RST_N   = ext_q;
  assign BUSY        = busy_q;
  assign RST_CAUSE   = cause_q;
  assign RST_COUNT   = count_q;
  assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_reset_request_gen.sv
// Randomised scoreboard bench: stimulus pushes expected low windows, gaps and completions;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_reset_request_gen;

  localparam int PULSE_LEN     = 8;
  localparam int ACK_TIMEOUT   = 1024;
  localparam int HOLDOFF_LEN   = 32;
  localparam int MAX_RETRY     = 3;
  localparam int LOCK_FILT_LEN = 16;
  localparam int SYNC_LAT      = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PLL_LOCK = 1'b0;
  logic       WDT_EXPIRE = 1'b0;
  logic       SW_RST_REQ = 1'b0;
  logic       FABRIC_RESET_N = 1'b1;
  logic       EXT_RST_N;
  logic       BUSY;
  logic [2:0] RST_CAUSE;
  logic [7:0] RST_COUNT;
  logic       TIMEOUT_ERR;

  reset_request_gen dut (
    .CLK            (CLK),
    .RST            (RST),
    .PLL_LOCK       (PLL_LOCK),
    .WDT_EXPIRE     (WDT_EXPIRE),
    .SW_RST_REQ     (SW_RST_REQ),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .EXT_RST_N      (EXT_RST_N),
    .BUSY           (BUSY),
    .RST_CAUSE      (RST_CAUSE),
    .RST_COUNT      (RST_COUNT),
    .TIMEOUT_ERR    (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] cause;
    logic [7:0] count;
  } done_t;

  int    exp_low_q[$];
  int    exp_gap_q[$];
  done_t exp_done_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_count = 0;

  int    fab_d = 3;
  int    fab_r = 20;
  bit    fab_stuck = 1'b0;
  int    rel_seen = 0;
  int    rel_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_low_len(input int d);
    // Fabric drops d cycles after EXT_RST_N falls, is seen after the synchroniser,
    // and acted on one cycle later; the pulse is never shorter than PULSE_LEN.
    int seen = d + SYNC_LAT + 1;
    return (seen > PULSE_LEN) ? seen : PULSE_LEN;
  endfunction

  // Monitor: compares every presented low window, retry gap and completion.
  logic  prev_ext = 1'b1;
  logic  prev_busy = 1'b0;
  int    fall_cyc = 0;
  int    rise_cyc = 0;
  done_t got_done;

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (prev_ext && !EXT_RST_N) begin
          if (prev_busy) begin
            check("gap_expected", exp_gap_q.size() > 0, 1);
            if (exp_gap_q.size() > 0) check("gap_len", cyc - rise_cyc, exp_gap_q.pop_front());
          end
          fall_cyc = cyc;
        end
        if (!prev_ext && EXT_RST_N) begin
          check("low_expected", exp_low_q.size() > 0, 1);
          if (exp_low_q.size() > 0) check("low_len", cyc - fall_cyc, exp_low_q.pop_front());
          rise_cyc = cyc;
        end
        if (prev_busy && !BUSY) begin
          check("done_expected", exp_done_q.size() > 0, 1);
          if (exp_done_q.size() > 0) begin
            got_done = exp_done_q.pop_front();
            check("done_cause", RST_CAUSE, got_done.cause);
            check("done_count", RST_COUNT, got_done.count);
            check("done_latency", cyc - rel_cyc, SYNC_LAT + 1 + HOLDOFF_LEN);
          end
        end
      end
      prev_ext  = EXT_RST_N;
      prev_busy = BUSY;
    end
  end

  // Reset controller model: drops FABRIC_RESET_N fab_d cycles after the request,
  // releases it fab_r cycles after the request is withdrawn.
  initial begin : fabric
    int n;
    forever begin
      @(posedge CLK);
      #1;
      if (!EXT_RST_N && !fab_stuck && !RST) begin
        repeat (fab_d) @(posedge CLK);
        #1;
        FABRIC_RESET_N = 1'b0;
        n = 0;
        while (!EXT_RST_N && n < 4 * ACK_TIMEOUT) begin
          @(posedge CLK);
          #1;
          n++;
        end
        repeat (fab_r) @(posedge CLK);
        #1;
        FABRIC_RESET_N = 1'b1;
        rel_cyc = cyc;
        rel_seen++;
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_req(input logic [2:0] c);
    step(1);
    SW_RST_REQ = c[0];
    WDT_EXPIRE = c[1];
    step(1);
    SW_RST_REQ = 1'b0;
    WDT_EXPIRE = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (BUSY && n < budget) begin
      step(1);
      n++;
    end
    check("idle_reached", BUSY, 0);
  endtask

  task automatic expect_seq(input logic [2:0] c, input int d);
    done_t t;
    exp_low_q.push_back(exp_low_len(d));
    exp_count = (exp_count < 255) ? exp_count + 1 : 255;
    t.cause = c;
    t.count = 8'(exp_count);
    exp_done_q.push_back(t);
  endtask

  task automatic run_seq(input logic [2:0] c, input int d, input int r, input bit poke,
                         input bit lock_poke);
    int r0;
    int n;
    fab_d = d;
    fab_r = r;
    expect_seq(c, d);
    r0 = rel_seen;
    pulse_req(c);
    if (lock_poke) begin
      PLL_LOCK = 1'b0;
      step(20);
      PLL_LOCK = 1'b1;
    end
    if (poke) begin
      pulse_req(3'b010);
      n = 0;
      while (rel_seen == r0 && n < 3000) begin
        step(1);
        n++;
      end
      step(10);
      pulse_req(3'b001);
    end
    wait_idle(4000);
    step(3);
  endtask

  task automatic lock_dip(input int len, input int d, input int r);
    fab_d = d;
    fab_r = r;
    if (len >= LOCK_FILT_LEN) expect_seq(3'b100, d);
    PLL_LOCK = 1'b0;
    step(len);
    PLL_LOCK = 1'b1;
    step(8);
    if (len >= LOCK_FILT_LEN) begin
      check("lock_event_busy", BUSY, 1);
      wait_idle(4000);
    end else begin
      step(40);
      check("lock_glitch_ignored", BUSY, 0);
    end
    step(25);
  endtask

  initial begin : stimulus
    int n;
    step(3);
    check("rst_ext", EXT_RST_N, 1);
    check("rst_busy", BUSY, 0);
    check("rst_cause", RST_CAUSE, 0);
    check("rst_count", RST_COUNT, 0);
    check("rst_err", TIMEOUT_ERR, 0);
    RST = 1'b0;
    PLL_LOCK = 1'b1;
    step(40);
    check("no_powerup_event", BUSY, 0);

    run_seq(3'b001, 3, 20, 1'b0, 1'b0);
    check("count_after_first", RST_COUNT, 1);
    run_seq(3'b011, 4, 10, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_seq(3'($urandom_range(1, 3)), $urandom_range(1, 10), $urandom_range(1, 30),
              (i == 3) ? 1'b0 : 1'($urandom_range(0, 1)), i == 3);
    end

    lock_dip(10, 3, 5);
    lock_dip(20, 3, 5);
    lock_dip(LOCK_FILT_LEN - 1, 2, 7);
    lock_dip(LOCK_FILT_LEN, 6, 9);
    for (int i = 0; i < 4; i++) lock_dip($urandom_range(8, 24), $urandom_range(1, 10), $urandom_range(1, 30));

    // Fabric never responds: every window and retry gap times out, then sticky error.
    fab_stuck = 1'b1;
    for (int i = 0; i <= MAX_RETRY; i++) exp_low_q.push_back(ACK_TIMEOUT);
    for (int i = 0; i < MAX_RETRY; i++) exp_gap_q.push_back(PULSE_LEN);
    pulse_req(3'b001);
    n = 0;
    while (!TIMEOUT_ERR && n < 6000) begin
      step(1);
      n++;
    end
    check("err_cycles", n, (MAX_RETRY + 1) * ACK_TIMEOUT + MAX_RETRY * PULSE_LEN);
    check("err_set", TIMEOUT_ERR, 1);
    check("err_ext", EXT_RST_N, 1);
    check("err_busy", BUSY, 1);
    pulse_req(3'b011);
    step(20);
    check("err_hold", TIMEOUT_ERR, 1);
    check("err_hold_busy", BUSY, 1);
    check("err_hold_ext", EXT_RST_N, 1);
    check("err_count", RST_COUNT, exp_count);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("err_clr", TIMEOUT_ERR, 0);
    check("err_clr_busy", BUSY, 0);
    step(3);
    RST = 1'b0;
    fab_stuck = 1'b0;
    exp_count = 0;
    step(40);

    // Reset mid-sequence while waiting for fabric release.
    run_seq(3'b010, 2, 5, 1'b0, 1'b0);
    fab_d = 3;
    fab_r = 60;
    exp_low_q.push_back(exp_low_len(3));
    pulse_req(3'b001);
    n = 0;
    while (!EXT_RST_N && n < 2000) begin
      step(1);
      n++;
    end
    step(3);
    check("wh_busy", BUSY, 1);
    check("wh_count", RST_COUNT, exp_count);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("midrst_ext", EXT_RST_N, 1);
    check("midrst_busy", BUSY, 0);
    check("midrst_cause", RST_CAUSE, 0);
    check("midrst_count", RST_COUNT, 0);
    step(3);
    RST = 1'b0;
    exp_count = 0;
    step(80);

    // Drive enough completions to reach and hold saturation.
    for (int i = 0; i < 257; i++) run_seq(3'b001, 1, 1, 1'b0, 1'b0);
    check("count_saturated", RST_COUNT, 255);

    step(10);
    check("low_q_drained", exp_low_q.size(), 0);
    check("gap_q_drained", exp_gap_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
